// File: rtl/vector_packer.sv
// rtl/vector_packer.sv - serial-to-parallel bit packer with valid/ready on both sides
//
// Purpose: collects WIDTH accepted serial bits into one packed word and
// presents it on a valid/ready output. The word is held until the consumer
// takes it.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   clear      - synchronous discard of any partial or held word
//   in_bit     - serial data bit
//   in_valid   - in_bit is valid
//   in_ready   - packer accepts in_bit this cycle
//   outv       - packed word (changes only when a word completes)
//   out_valid  - outv holds a complete word awaiting hand-off
//   out_ready  - consumer takes outv this cycle
//   bit_count  - bits accepted into the current word (0..WIDTH)

module vector_packer #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] outv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_count
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] outv_q, outv_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] sr_shift;
  logic             accept;

  // Shifted value including the bit presented this cycle; also the completed
  // word when this is the WIDTH-th bit.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shift = {sr_q[WIDTH-2:0], in_bit};
    end else begin
      sr_shift = {in_bit, sr_q[WIDTH-1:1]};
    end
  end

  // In HOLD a new bit may only enter on the same edge the held word leaves.
  always_comb begin
    in_ready = 1'b0;
    if (!clear) begin
      in_ready = (state_q == ST_FILL) ? 1'b1 : out_ready;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    outv_d  = outv_q;
    cnt_d   = cnt_q;

    if (clear) begin
      // outv deliberately keeps its last value.
      state_d = ST_FILL;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (accept) begin
            sr_d = sr_shift;
            if (cnt_q == CNT_LAST) begin
              outv_d  = sr_shift;
              cnt_d   = CNT_FULL;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_FILL;
            // Old word bits left in sr are fully shifted out before the
            // next completion, so sr need not be cleared on hand-off.
            if (accept) begin
              sr_d  = sr_shift;
              cnt_d = CNT_ONE;
            end else begin
              cnt_d = '0;
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      sr_q    <= '0;
      outv_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      outv_q  <= outv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign outv      = outv_q;
  assign out_valid = (state_q == ST_HOLD);
  assign bit_count = cnt_q;

endmodule

// File: doc/vector_packer.md
# vector_packer

Serial-to-parallel bit packer. Accepts one bit per handshake on a valid/ready input and assembles `WIDTH` accepted bits into a packed vector. Presents the vector on a valid/ready output. It is the assembly-side counterpart to the design's vector bit-split logic: individual bit lines go in, a packed `outv` word comes out, for blocks that consume whole vectors.

## Interface
Parameters:
- `WIDTH`, 3: bits per packed word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = first accepted bit lands in `outv[WIDTH-1]`; 0 = first accepted bit lands in `outv[0]`.

Ports:
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `clear`  input  1  synchronous discard of any partial or held word.
- `in_bit`  input  1  serial data bit.
- `in_valid`  input  1  `in_bit` is valid.
- `in_ready`  output  1  packer accepts `in_bit` this cycle.
- `outv`  output  WIDTH  packed word.
- `out_valid`  output  1  `outv` holds a complete word.
- `out_ready`  input  1  consumer takes `outv` this cycle.
- `bit_count`  output  CW = $clog2(WIDTH+1)  bits accepted into the current word.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Hand-off: `out_valid && out_ready` at a rising edge.
- States:
  - FILL: assembling a word.
  - HOLD: a complete word is waiting for hand-off.
- Shift register `sr[WIDTH-1:0]`:
  - `MSB_FIRST=1`: on accept, `sr <= {sr[WIDTH-2:0], in_bit}`.
  - `MSB_FIRST=0`: on accept, `sr <= {in_bit, sr[WIDTH-1:1]}`.
- FILL:
  - `in_ready = !clear`, `out_valid = 0`.
  - Each accept increments `bit_count`.
  - When the accepted bit is the WIDTH-th:
    - `outv` loads the completed word, i.e. the shifted value including this bit.
    - `bit_count` becomes `WIDTH`.
    - State goes to HOLD.
- HOLD:
  - `out_valid = 1`, `in_ready = out_ready && !clear`.
  - Hand-off without accept: go to FILL, `bit_count = 0`.
  - Hand-off with simultaneous accept: go to FILL, `bit_count = 1`, and the accepted bit is the first bit of the next word.
  - No hand-off: `outv` stays stable and no bits are accepted.
- `clear` (priority over all handshakes except reset):
  - Next state FILL, `bit_count = 0`, `out_valid = 0`, `sr = 0`.
  - `outv` retains its last value.
  - No bit is accepted in the clear cycle, because `in_ready` is forced low.
- `outv` changes only when a word completes; it never shows a partial word.
- `in_bit` is ignored whenever `in_valid` is low.

## Timing
- Reset (async assert, any time, including mid-word or during HOLD):
  - state FILL, `sr = 0`, `outv = 0`, `out_valid = 0`, `bit_count = 0`.
  - `in_ready` reads 1 once `clear` is low.
  - A partial word is lost.
- Release of `rst_n` is synchronous to `clk`. The first accept is possible at the first rising edge after release.
- Latency: `out_valid` and the new `outv` are visible immediately after the edge that accepts the WIDTH-th bit. That is 0 additional cycles, and both are registered outputs.
- Throughput: with `out_ready` held 1 and `in_valid` held 1, one bit is accepted every cycle with no gaps. `out_valid` pulses for one cycle every `WIDTH` cycles.
- Backpressure: with `out_ready = 0` in HOLD, `in_ready = 0` and the word is held indefinitely.
- Combinational paths: `in_ready` depends on state, `out_ready` and `clear` only. `out_valid`, `outv` and `bit_count` are pure register outputs.
- `bit_count` wraps only by completion/hand-off; it never exceeds `WIDTH`.

## Test plan
- Basic packing, `WIDTH=3`, `MSB_FIRST=1`, `out_ready=1`:
  - Stimulus: bits 1,0,1 on consecutive cycles.
  - Required: `outv = 3'b101` and `out_valid = 1` after the 3rd accept edge, for exactly one cycle.
  - Required: `bit_count` steps 1, 2, 3, 0.
- LSB-first, `MSB_FIRST=0`:
  - Stimulus: bits 1,1,0.
  - Required: `outv = 3'b011`.
- Back-to-back streaming, `MSB_FIRST=1`:
  - Stimulus: continuous bits 1,1,0, 0,1,0.
  - Required: `outv` = `3'b110` then `3'b010`.
  - Required: `in_ready` never drops.
  - Required: the 4th bit is accepted on the hand-off cycle with `bit_count = 1`.
- Backpressure:
  - Stimulus: complete word `3'b100`, hold `out_ready = 0` for 5 cycles with `in_valid = 1`.
  - Required: `in_ready = 0`, `outv` stable at `3'b100`, `out_valid = 1`.
  - Then raise `out_ready`: required hand-off, and the pending bit is accepted in that same cycle.
- Clear mid-word:
  - Stimulus: accept 1,1, assert `clear` one cycle, then send 0,0,1.
  - Required: `bit_count = 0` after clear, `in_ready = 0` during the clear cycle.
  - Required: next word `outv = 3'b001`, with previous `outv` unchanged until then.
- Reset mid-operation:
  - Stimulus: pulse `rst_n` low asynchronously in HOLD.
  - Required: `outv = 0`, `out_valid = 0` and `bit_count = 0` immediately, without waiting for a clock edge.
  - Required: a fresh word 0,1,1 after reset gives `outv = 3'b011`.
